// File: rtl/threshold_detector_if.sv
// Sample/threshold bus for threshold_detector: the master drives samples and
// configuration, the slave returns the debounced flag, edge pulses and count.
interface threshold_detector_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] thr_hi;
  logic [WIDTH-1:0] thr_lo;
  logic             mode;
  logic             b;
  logic             rise;
  logic             fall;
  logic [CNT_W-1:0] events;

  modport master (
    output in_valid, a, thr_hi, thr_lo, mode,
    input  b, rise, fall, events
  );

  modport slave (
    input  in_valid, a, thr_hi, thr_lo, mode,
    output b, rise, fall, events
  );
endinterface

// File: rtl/threshold_detector.sv
// Debounced hysteresis threshold detector with edge pulses and a saturating
// count of rising edges. All outputs are registered.
module threshold_detector #(
  parameter int WIDTH    = 4,
  parameter int DEBOUNCE = 3,
  parameter int CNT_W    = 8
) (
  input logic                 clk,
  input logic                 rst,
  threshold_detector_if.slave bus
);

  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] DEB_C = CW'(DEBOUNCE);

  typedef enum logic [1:0] {
    IDLE,
    ARMING,
    ACTIVE,
    RELEASING
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d, cnt_inc;
  logic             mode_q;
  logic             set_qual, clr_qual;
  logic             b_d;
  logic             b_q, rise_q, fall_q;
  logic [CNT_W-1:0] events_q;

  // Strict unsigned comparisons; the sense of set/clear swaps with mode.
  always_comb begin
    set_qual = '0;
    clr_qual = '0;
    if (bus.mode) begin
      set_qual = bus.a < bus.thr_lo;
      clr_qual = bus.a > bus.thr_hi;
    end else begin
      set_qual = bus.a > bus.thr_hi;
      clr_qual = bus.a < bus.thr_lo;
    end
  end

  // Next-state and debounce counter. IDLE/ACTIVE always hold cnt_q=0, so the
  // first qualifying sample shares the ARMING/RELEASING terminal-count test,
  // which also covers DEBOUNCE=1 going straight across.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cnt_inc = cnt_q + 1'b1;
    if (bus.mode != mode_q) begin
      cnt_d = '0;
      if (state_q == ARMING)    state_d = IDLE;
      if (state_q == RELEASING) state_d = ACTIVE;
    end else if (bus.in_valid) begin
      case (state_q)
        IDLE, ARMING: begin
          if (set_qual) begin
            if (cnt_inc == DEB_C) begin
              state_d = ACTIVE;
              cnt_d   = '0;
            end else begin
              state_d = ARMING;
              cnt_d   = cnt_inc;
            end
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        default: begin
          if (clr_qual) begin
            if (cnt_inc == DEB_C) begin
              state_d = IDLE;
              cnt_d   = '0;
            end else begin
              state_d = RELEASING;
              cnt_d   = cnt_inc;
            end
          end else begin
            state_d = ACTIVE;
            cnt_d   = '0;
          end
        end
      endcase
    end
    b_d = (state_d == ACTIVE) || (state_d == RELEASING);
  end

  // State, mode register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mode_q   <= bus.mode;
      b_q      <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      events_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= bus.mode;
      b_q     <= b_d;
      rise_q  <= b_d & ~b_q;
      fall_q  <= ~b_d & b_q;
      if (b_d && !b_q && events_q != '1) events_q <= events_q + 1'b1;
    end
  end

  assign bus.b      = b_q;
  assign bus.rise   = rise_q;
  assign bus.fall   = fall_q;
  assign bus.events = events_q;

endmodule

// File: tb/tb_threshold_detector.sv
// Self-checking bench for threshold_detector: directed scenarios plus random
// traffic against a run-length reference model. A second instance with a
// 2-bit counter exercises event saturation.
module tb_threshold_detector;

  localparam int DEB = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       mode;
  logic [3:0] a;
  logic [3:0] thr_hi;
  logic [3:0] thr_lo;

  int vectors    = 0;
  int miscompares = 0;

  // reference model state
  bit m_b, m_rise, m_fall, m_mode;
  int m_run, m_ev, m_ev2;

  threshold_detector_if #(.WIDTH(4), .CNT_W(8)) bus1 ();
  threshold_detector_if #(.WIDTH(4), .CNT_W(2)) bus2 ();

  assign bus1.in_valid = in_valid;
  assign bus1.a        = a;
  assign bus1.thr_hi   = thr_hi;
  assign bus1.thr_lo   = thr_lo;
  assign bus1.mode     = mode;
  assign bus2.in_valid = in_valid;
  assign bus2.a        = a;
  assign bus2.thr_hi   = thr_hi;
  assign bus2.thr_lo   = thr_lo;
  assign bus2.mode     = mode;

  threshold_detector #(.WIDTH(4), .DEBOUNCE(DEB), .CNT_W(8)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  threshold_detector #(.WIDTH(4), .DEBOUNCE(DEB), .CNT_W(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2.slave)
  );

  always #5 clk = ~clk;

  // One clock of the detector described as a run length of consecutive
  // qualifying valid samples toward the opposite state of b.
  task automatic model_step();
    bit above, below, want;
    if (rst) begin
      m_b = 0; m_rise = 0; m_fall = 0; m_run = 0;
      m_mode = mode; m_ev = 0; m_ev2 = 0;
    end else begin
      m_rise = 0;
      m_fall = 0;
      if (mode != m_mode) begin
        m_mode = mode;
        m_run  = 0;
      end else if (in_valid) begin
        above = (int'(a) > int'(thr_hi));
        below = (int'(a) < int'(thr_lo));
        want  = (m_b ^ m_mode) ? below : above;
        if (want) begin
          m_run++;
          if (m_run == DEB) begin
            m_run = 0;
            m_b   = !m_b;
            if (m_b) begin
              m_rise = 1;
              if (m_ev  < 255) m_ev++;
              if (m_ev2 < 3)   m_ev2++;
            end else begin
              m_fall = 1;
            end
          end
        end else begin
          m_run = 0;
        end
      end
    end
  endtask

  // Drive one cycle of inputs, update the model at the edge, sample after it.
  task automatic cycle(input logic r, input logic v, input logic [3:0] av, input logic md);
    rst = r; in_valid = v; a = av; mode = md;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    thr_hi = 4'd10; thr_lo = 4'd5;
    cycle(1, 1, 15, 0);
    cycle(1, 1, 15, 0);
    vectors++;
    if ({bus1.b, bus1.rise, bus1.fall, bus1.events} !== 11'd0) begin
      miscompares++;
      $display("FAIL reset: got b/r/f/ev=%b%b%b %0d want 000 0", bus1.b, bus1.rise, bus1.fall, bus1.events);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 11, 0);
      vectors++;
      if ({bus1.b, bus1.rise, bus1.fall, bus1.events} !== {m_b, m_rise, m_fall, 8'(m_ev)}) begin
        miscompares++;
        $display("FAIL reset_arm[%0d]: got %b%b%b %0d want %b%b%b %0d", i, bus1.b, bus1.rise, bus1.fall, bus1.events, m_b, m_rise, m_fall, m_ev);
      end
    end
    vectors++;
    if ({bus1.b, bus1.rise, bus1.events} !== {1'b1, 1'b1, 8'd1}) begin
      miscompares++;
      $display("FAIL reset_first_rise: got b=%b rise=%b ev=%0d want 1 1 1", bus1.b, bus1.rise, bus1.events);
    end
    cycle(0, 0, 0, 0);
    vectors++;
    if (bus1.rise !== 1'b0) begin
      miscompares++;
      $display("FAIL rise_one_cycle: got rise=%b want 0", bus1.rise);
    end
  endtask

  task automatic test_debounce_break();
    logic [3:0] seq [6] = '{4'd11, 4'd11, 4'd7, 4'd11, 4'd11, 4'd11};
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      cycle(0, 1, seq[i], 0);
      vectors++;
      if ({bus1.b, bus1.rise, bus1.fall} !== {m_b, m_rise, m_fall} || bus1.b !== (i == 5)) begin
        miscompares++;
        $display("FAIL debounce_break[%0d]: got b=%b r=%b f=%b want b=%b r=%b f=%b", i, bus1.b, bus1.rise, bus1.fall, m_b, m_rise, m_fall);
      end
    end
  endtask

  task automatic test_gaps_hysteresis();
    logic       vs  [13] = '{1,0,1,0,1, 1,1,1,1,1, 1,1,1};
    logic [3:0] as  [13] = '{11,11,11,11,11, 5,5,5,5,5, 4,4,4};
    logic       eb  [13] = '{0,0,0,0,1, 1,1,1,1,1, 1,1,0};
    logic       ef  [13] = '{0,0,0,0,0, 0,0,0,0,0, 0,0,1};
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 13; i++) begin
      cycle(0, vs[i], as[i], 0);
      vectors++;
      if ({bus1.b, bus1.fall} !== {eb[i], ef[i]} || {bus1.b, bus1.rise, bus1.fall} !== {m_b, m_rise, m_fall}) begin
        miscompares++;
        $display("FAIL gaps_hyst[%0d]: got b=%b r=%b f=%b want b=%b r=%b f=%b", i, bus1.b, bus1.rise, bus1.fall, eb[i], m_rise, ef[i]);
      end
    end
    cycle(0, 0, 0, 0);
    vectors++;
    if (bus1.fall !== 1'b0) begin
      miscompares++;
      $display("FAIL fall_one_cycle: got fall=%b want 0", bus1.fall);
    end
  endtask

  task automatic test_mode_change();
    logic       vs [10] = '{1,1, 1,1,1,1, 0, 1,1,1};
    logic [3:0] as [10] = '{4,4, 4,4,4,4, 3, 3,3,3};
    logic       ms [10] = '{1,1, 0,0,0,0, 1, 1,1,1};
    logic       eb [10] = '{0,0, 0,0,0,0, 0, 0,0,1};
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      cycle(0, vs[i], as[i], ms[i]);
      vectors++;
      if (bus1.b !== eb[i] || {bus1.b, bus1.rise, bus1.fall, bus1.events} !== {m_b, m_rise, m_fall, 8'(m_ev)}) begin
        miscompares++;
        $display("FAIL mode_change[%0d]: got b=%b r=%b f=%b ev=%0d want b=%b r=%b f=%b ev=%0d", i, bus1.b, bus1.rise, bus1.fall, bus1.events, eb[i], m_rise, m_fall, m_ev);
      end
    end
    vectors++;
    if (bus1.rise !== 1'b1) begin
      miscompares++;
      $display("FAIL mode1_rise: got rise=%b want 1", bus1.rise);
    end
  endtask

  task automatic test_saturation();
    int exp2 [5] = '{1, 2, 3, 3, 3};
    cycle(1, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 3; i++) cycle(0, 1, 11, 0);
      vectors++;
      if (int'(bus2.events) != exp2[k] || int'(bus2.events) != m_ev2 || int'(bus1.events) != k + 1 || bus2.rise !== 1'b1) begin
        miscompares++;
        $display("FAIL saturation[%0d]: got ev2=%0d ev1=%0d rise2=%b want ev2=%0d ev1=%0d rise2=1", k, bus2.events, bus1.events, bus2.rise, exp2[k], k + 1);
      end
      for (int i = 0; i < 3; i++) cycle(0, 1, 4, 0);
    end
  endtask

  task automatic test_reset_mid();
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 1, 11, 0);
    cycle(0, 1, 4, 0);
    cycle(0, 1, 4, 0);
    cycle(1, 1, 4, 0);
    vectors++;
    if ({bus1.b, bus1.rise, bus1.fall, bus1.events} !== 11'd0) begin
      miscompares++;
      $display("FAIL reset_mid: got b/r/f/ev=%b%b%b %0d want 000 0", bus1.b, bus1.rise, bus1.fall, bus1.events);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 11, 0);
      vectors++;
      if (bus1.b !== (i == 2) || {bus1.b, bus1.rise, bus1.fall} !== {m_b, m_rise, m_fall}) begin
        miscompares++;
        $display("FAIL reset_mid_rearm[%0d]: got b=%b r=%b f=%b want b=%b r=%b f=%b", i, bus1.b, bus1.rise, bus1.fall, m_b, m_rise, m_fall);
      end
    end
  endtask

  task automatic test_random();
    logic r, v, md;
    logic [3:0] av;
    md = 1'b0;
    cycle(1, 0, 0, md);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        thr_hi = 4'($urandom_range(0, 15));
        thr_lo = 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 39) == 0) md = ~md;
      r  = ($urandom_range(0, 99) == 0);
      v  = ($urandom_range(0, 3) != 0);
      av = 4'($urandom_range(0, 15));
      cycle(r, v, av, md);
      vectors++;
      if ({bus1.b, bus1.rise, bus1.fall, bus1.events} !== {m_b, m_rise, m_fall, 8'(m_ev)} ||
          {bus2.b, bus2.rise, bus2.fall, bus2.events} !== {m_b, m_rise, m_fall, 2'(m_ev2)} ||
          (bus1.rise && bus1.fall)) begin
        miscompares++;
        $display("FAIL random[%0d]: got b=%b r=%b f=%b ev=%0d ev2=%0d want b=%b r=%b f=%b ev=%0d ev2=%0d", i, bus1.b, bus1.rise, bus1.fall, bus1.events, bus2.events, m_b, m_rise, m_fall, m_ev, m_ev2);
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; mode = 1'b0;
    thr_hi = 4'd10; thr_lo = 4'd5;
    #1;
    test_reset();
    test_debounce_break();
    test_gaps_hysteresis();
    test_mode_change();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/threshold_detector.md
# threshold_detector

Parametrised, clocked successor to the 4-bit combinational comparator. It compares an unsigned WIDTH-bit sample stream against programmable high and low thresholds with hysteresis. The output flag changes state only after DEBOUNCE consecutive qualifying samples. It also generates edge pulses and keeps a saturating event count. It sits between a sampled data source and downstream control or alarm logic.

## Interface
- WIDTH, 4: sample and threshold width in bits, at least 1.
- DEBOUNCE, 3: consecutive qualifying samples needed to change state, at least 1.
- CNT_W, 8: event counter width, at least 1.

- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  sample qualifier; `a` is evaluated only when in_valid=1.
- a  input  WIDTH  unsigned sample.
- thr_hi  input  WIDTH  unsigned upper threshold.
- thr_lo  input  WIDTH  unsigned lower threshold.
- mode  input  1  0 = detect above (assert high), 1 = detect below (assert low).
- b  output  1  registered, debounced detection flag.
- rise  output  1  one-cycle pulse when b goes 0 to 1.
- fall  output  1  one-cycle pulse when b goes 1 to 0.
- events  output  CNT_W  count of rise pulses since reset; saturates at all-ones.

## Operation
- All comparisons are unsigned and strict. Equal values never qualify.
- Qualifying condition, mode 0:
  - set when a > thr_hi;
  - clear when a < thr_lo.
- Qualifying condition, mode 1:
  - set when a < thr_lo;
  - clear when a > thr_hi.
- FSM states and transitions:
  - IDLE (b=0): a valid set-qualifying sample moves to ARMING. When DEBOUNCE=1, it moves directly to ACTIVE.
  - ARMING (b=0): each valid set-qualifying sample increments the debounce counter. When the DEBOUNCE-th sample arrives, go to ACTIVE. A valid non-qualifying sample clears the counter and returns to IDLE.
  - ACTIVE (b=1): a valid clear-qualifying sample moves to RELEASING. When DEBOUNCE=1, it moves directly to IDLE.
  - RELEASING (b=1): same counting as ARMING, using the clear condition. The DEBOUNCE-th sample goes to IDLE. A valid non-qualifying sample returns to ACTIVE and clears the counter.
- Cycles with in_valid=0 hold both state and counter. Qualifying samples need not be on adjacent clock cycles, only adjacent valid samples.
- Hysteresis band:
  - samples inside [thr_lo, thr_hi] qualify for neither direction;
  - they break any count in progress.
- Misconfiguration (thr_lo > thr_hi): comparisons are applied literally. No error is flagged.
- Mode change:
  - mode is registered internally;
  - any cycle where mode differs from the registered value clears the counter;
  - ARMING returns to IDLE and RELEASING returns to ACTIVE;
  - b is unchanged;
  - that cycle's sample is not evaluated.
- Debounce counter width is clog2(DEBOUNCE+1). It never exceeds DEBOUNCE.
- events increments by 1 in the same cycle rise is asserted, and holds at 2^CNT_W-1 once reached.

## Timing
- Reset values: b=0, rise=0, fall=0, events=0. FSM is IDLE, counter is 0, and the mode register takes the current mode.
- Reset mid-count or while ACTIVE returns every output to its reset value on the next edge. No fall pulse is generated.
- Latency: the edge that samples the DEBOUNCE-th qualifying valid sample updates b. b, rise or fall, and events are visible in the following cycle, one cycle after the sample is presented.
- rise and fall are high for exactly one clock and are never high together.
- b, rise, fall and events are all registered outputs. No combinational path runs from input to output.
- Threshold inputs are used live each valid cycle and need no setup beyond normal synchronous timing.

## Test plan
All scenarios use WIDTH=4, DEBOUNCE=3, CNT_W=8, thr_hi=10, thr_lo=5, mode=0 unless stated.

- Reset: hold rst=1 for 2 cycles with a=15 and in_valid=1 -> b=0, rise=0, fall=0, events=0. Three valid a=11 samples after release -> b=1 and rise=1 for one cycle on the cycle after the third sample; events=1.
- Debounce break: valid a=11, 11, 7, 11, 11 -> b stays 0 throughout. A further a=11 -> b=1.
- Gaps, hysteresis and equality:
  - a=11 with in_valid toggling 1,0,1,0,1 -> b=1 after the third valid sample.
  - Then a=5 ×5 (equal to thr_lo) -> b stays 1.
  - Then a=4 ×3 -> b=0 and a one-cycle fall pulse.
- Mode 1 and mode change:
  - mode=1, a=4 ×2, then toggle mode to 0, then a=4 ×3 -> b stays 0.
  - mode=1 again, then a=3 ×3 -> b=1 with a rise pulse.
- Saturation: use CNT_W=2 and drive 5 full set/clear cycles -> events reads 1, 2, 3, 3, 3.
- Reset mid-operation: in ACTIVE with the counter at 2 in RELEASING, assert rst for 1 cycle -> b=0, no fall pulse, events=0. The next a=11 sample only begins ARMING.
